// File: rtl/burst_write_pkg.sv
// Shared state encoding and default widths for the Avalon-MM burst write master.
package burst_write_pkg;

    localparam int BWM_ADDRESS_WIDTH     = 32;
    localparam int BWM_DATA_WIDTH        = 32;
    localparam int BWM_BYTE_ENABLE_WIDTH = 4;
    localparam int BWM_BURST_WIDTH       = 4;
    localparam int BWM_FIFO_DEPTH        = 8;
    localparam int BWM_FIFO_WIDTHU       = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_WAITDATA = 4'b0010,
        ST_BURST    = 4'b0100,
        ST_DONE     = 4'b1000
    } state_t;

endpackage

// File: rtl/burst_write_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on q one cycle after it is pushed.
module burst_write_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int WIDTHU = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrreq,
    input  logic [WIDTH-1:0]  data,
    input  logic              rdreq,
    output logic [WIDTH-1:0]  q,
    output logic              full,
    output logic              empty,
    output logic [WIDTHU:0]   usedw
);

    localparam logic [WIDTHU:0] FULL_LVL = (WIDTHU+1)'(DEPTH);
    localparam logic [WIDTHU:0] PTR_ONE  = (WIDTHU+1)'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTHU:0]   r_wr_ptr;
    logic [WIDTHU:0]   r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign usedw  = r_wr_ptr - r_rd_ptr;
    assign full   = (usedw == FULL_LVL);
    assign empty  = (usedw == '0);
    assign w_push = wrreq & ~full;
    assign w_pop  = rdreq & ~empty;
    assign q      = r_mem[r_rd_ptr[WIDTHU-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[WIDTHU-1:0]] <= data;
    end

endmodule

// File: rtl/burst_write_master.sv
// Avalon-MM bursting write master fed by a show-ahead FIFO.
// Optional per-beat byte enables: define BURST_WRITE_MASTER_BYTEENABLE_EN.
module burst_write_master
    import burst_write_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = BWM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = BWM_DATA_WIDTH,
    parameter int BYTE_ENABLE_WIDTH = BWM_BYTE_ENABLE_WIDTH,
    parameter int BURST_WIDTH       = BWM_BURST_WIDTH,
    parameter int FIFO_DEPTH        = BWM_FIFO_DEPTH,
    parameter int FIFO_WIDTHU       = BWM_FIFO_WIDTHU
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    input  logic                         ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
    input  logic [BURST_WIDTH-1:0]       ctrl_burstcount,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    input  logic                         ctrl_write,
    input  logic [DATA_WIDTH-1:0]        ctrl_writedata,
`ifdef BURST_WRITE_MASTER_BYTEENABLE_EN
    input  logic [BYTE_ENABLE_WIDTH-1:0] ctrl_byteenable,
`endif
    output logic                         ctrl_full,
    output logic [FIFO_WIDTHU:0]         ctrl_used
);

`ifdef BURST_WRITE_MASTER_BYTEENABLE_EN
    localparam int FIFO_W = DATA_WIDTH + BYTE_ENABLE_WIDTH;
`else
    localparam int FIFO_W = DATA_WIDTH;
`endif
    localparam int CMP_W = (BURST_WIDTH > FIFO_WIDTHU + 1) ? BURST_WIDTH : FIFO_WIDTHU + 1;
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [BURST_WIDTH-1:0]   r_burstcount;
    logic [BURST_WIDTH-1:0]   r_beat;
    logic                     r_write;
    logic                     r_busy;
    logic                     r_done;

    logic [FIFO_W-1:0]        w_fifo_din;
    logic [FIFO_W-1:0]        w_fifo_q;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [FIFO_WIDTHU:0]     w_used;
    logic                     w_beat;
    logic                     w_last;
    logic                     w_clamp;
    logic                     w_data_ready;
    logic [BURST_WIDTH-1:0]   w_start_count;

`ifdef BURST_WRITE_MASTER_BYTEENABLE_EN
    assign w_fifo_din        = {ctrl_byteenable, ctrl_writedata};
    assign master_byteenable = w_fifo_q[FIFO_W-1 -: BYTE_ENABLE_WIDTH];
`else
    assign w_fifo_din        = ctrl_writedata;
    assign master_byteenable = '1;
`endif

    burst_write_fifo #(
        .WIDTH  (FIFO_W),
        .DEPTH  (FIFO_DEPTH),
        .WIDTHU (FIFO_WIDTHU)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wrreq (ctrl_write),
        .data  (w_fifo_din),
        .rdreq (w_beat),
        .q     (w_fifo_q),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .usedw (w_used)
    );

    // A burst never asks for more words than the FIFO can ever hold.
    assign w_clamp       = CMP_W'(ctrl_burstcount) > CMP_W'(FIFO_DEPTH);
    assign w_start_count = w_clamp ? BURST_WIDTH'(FIFO_DEPTH) : ctrl_burstcount;
    assign w_data_ready  = CMP_W'(w_used) >= CMP_W'(r_burstcount);
    assign w_beat        = r_write & ~master_waitrequest & ~w_fifo_empty;
    assign w_last        = (r_beat == r_burstcount - BURST_ONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_burstcount <= '0;
            r_beat       <= '0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        r_address    <= ctrl_baseaddress;
                        r_burstcount <= w_start_count;
                        r_beat       <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_WAITDATA;
                    end
                end
                ST_WAITDATA: begin
                    // A zero-length request completes without touching the bus.
                    if (r_burstcount == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_data_ready) begin
                        r_write <= 1'b1;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_beat) begin
                        r_beat <= r_beat + BURST_ONE;
                        if (w_last) begin
                            r_write <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!ctrl_start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign master_address    = r_address;
    assign master_burstcount = r_burstcount;
    assign master_write      = r_write;
    assign master_writedata  = w_fifo_q[DATA_WIDTH-1:0];
    assign ctrl_busy         = r_busy;
    assign ctrl_done         = r_done;
    assign ctrl_full         = w_fifo_full;
    assign ctrl_used         = w_used;

endmodule

// File: doc/burst_write_master.md
# burst_write_master

Avalon-MM bursting write master, the write-direction counterpart of the team's burst read master. The control side pushes data words into an internal show-ahead FIFO and then requests one burst at a base address. The block issues one Avalon burst write of `ctrl_burstcount` beats to SDRAM once the FIFO holds the full burst. It sits between a pixel/stream producer and the HPS/SDRAM Avalon fabric.

## Interface
- `ADDRESS_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data beat width.
- `BYTE_ENABLE_WIDTH`, 4: DATA_WIDTH/8.
- `BURST_WIDTH`, 4: burstcount width; max burst is 2^BURST_WIDTH-1.
- `FIFO_DEPTH`, 8: FIFO words, a power of two.
- `FIFO_WIDTHU`, 3: log2(FIFO_DEPTH).

Ports:
- `clk` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `master_address` out ADDRESS_WIDTH: burst base address.
- `master_write` out 1: Avalon write request.
- `master_writedata` out DATA_WIDTH: current beat, equal to the FIFO head.
- `master_burstcount` out BURST_WIDTH: burst length.
- `master_byteenable` out BYTE_ENABLE_WIDTH: beat byte enables.
- `master_waitrequest` in 1: slave stall.
- `ctrl_start` in 1: level request for one burst.
- `ctrl_baseaddress` in ADDRESS_WIDTH: sampled on start.
- `ctrl_burstcount` in BURST_WIDTH: sampled on start.
- `ctrl_busy` out 1: burst in progress.
- `ctrl_done` out 1: burst complete; held until `ctrl_start` falls.
- `ctrl_write` in 1: FIFO push strobe.
- `ctrl_writedata` in DATA_WIDTH: push data.
- `ctrl_byteenable` in BYTE_ENABLE_WIDTH: push enables (only when `BURST_WRITE_MASTER_BYTEENABLE_EN` is defined).
- `ctrl_full` out 1: FIFO full.
- `ctrl_used` out FIFO_WIDTHU+1: FIFO occupancy, 0..FIFO_DEPTH.

## Operation
State machine, one-hot encoded: `ST_IDLE`, `ST_WAITDATA`, `ST_BURST`, `ST_DONE`.
- **ST_IDLE**, on `ctrl_start`=1:
  - Latch address and count into `master_address` and `master_burstcount`. Counts above FIFO_DEPTH are clamped to FIFO_DEPTH.
  - Set `ctrl_busy`=1 and clear the beat counter. Go to ST_WAITDATA.
  - If the count is 0: no bus activity; go straight to ST_DONE.
- **ST_WAITDATA**: when `ctrl_used` >= the latched count, set `master_write`=1 and go to ST_BURST.
- **ST_BURST**:
  - A beat is accepted on each cycle with `master_write`=1 and `master_waitrequest`=0. That beat pops the FIFO and increments the beat counter.
  - On the beat where counter = count-1: `master_write`<=0, `ctrl_busy`<=0, `ctrl_done`<=1, go to ST_DONE.
- **ST_DONE**: when `ctrl_start`=0, `ctrl_done`<=0 and go to ST_IDLE.
- Avalon rules:
  - `master_address` and `master_burstcount` stay constant for the whole burst.
  - `master_write`, `master_writedata` and `master_byteenable` stay stable while `master_waitrequest`=1.
  - `master_write` never drops mid-burst.
- FIFO behaviour:
  - A push while `ctrl_full`=1 is dropped, even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves `ctrl_used` unchanged.
  - Pushes are allowed in every state.
- Beat counter is BURST_WIDTH wide and never wraps within a legal burst.

## Timing
- Reset values: `master_address`=0, `master_write`=0, `master_burstcount`=0, `master_writedata`=FIFO head (don't-care, FIFO empty), `master_byteenable`=all ones, `ctrl_busy`=0, `ctrl_done`=0, `ctrl_full`=0, `ctrl_used`=0. State is ST_IDLE; FIFO pointers cleared.
- Reset asserted mid-burst: `master_write` is 0 after the next edge, the FIFO is flushed and no further beats are issued.
- Push to `ctrl_used` increment: 1 cycle. Push to the word being visible at the FIFO head: 1 cycle (show-ahead).
- Start to first `master_write`: 2 cycles minimum (IDLE→WAITDATA→BURST) when the FIFO already holds the burst.
- With no waitrequest, an N-beat burst occupies N consecutive cycles. `ctrl_done` rises on the edge after the last beat.

## Configuration
- `BURST_WRITE_MASTER_BYTEENABLE_EN` defined:
  - The FIFO stores `{ctrl_byteenable, ctrl_writedata}` (width DATA_WIDTH+BYTE_ENABLE_WIDTH).
  - `master_byteenable` is taken from the FIFO head.
- Undefined:
  - The `ctrl_byteenable` port is absent and the FIFO is DATA_WIDTH wide.
  - `master_byteenable` is constant all ones.

## Structure
- Package `burst_write_pkg` holds:
  - the state localparams `ST_IDLE`=4'b0001, `ST_WAITDATA`=4'b0010, `ST_BURST`=4'b0100, `ST_DONE`=4'b1000;
  - the default width constants.
- Sub-module `burst_write_fifo`: synchronous show-ahead FIFO with parameterised width and depth, with outputs `q`, `full`, `empty` and `usedw` (FIFO_WIDTHU+1 bits).
- Top-level FSM and counters live in `burst_write_master`.

## Test plan
- Push 8 words 0x1..0x8, then start with address 0x39000000, count 8, waitrequest=0 → exactly 8 consecutive beats at constant address/burstcount 8, data 0x1..0x8; `ctrl_done`=1; `ctrl_used`=0.
- Same setup, but waitrequest=1 for 3 cycles on beats 0 and 5 → data held during each stall, total of 8 beats, no beat duplicated.
- Start with count 4 while only 2 words are buffered → stays in ST_WAITDATA with `master_write`=0; burst starts 1 cycle after the 4th push has registered.
- Push 9 words with no start → `ctrl_full`=1 at 8; the 9th word is dropped; the burst writes words 1..8.
- Start with count 0 → no `master_write`; `ctrl_done`=1 two cycles later; clears 1 cycle after `ctrl_start`=0.
- Assert `reset`=0 during beat 3 of 8 → `master_write`=0, `ctrl_used`=0 and `ctrl_busy`=0 after the edge. With the byteenable macro defined, pushed enables 4'b0011 appear on `master_byteenable`.
